// File: rtl/sam_pwm_tx.sv
// SAM decoder transmit stage: shifts a config frame on str with mode=1, then sends message words as PWM symbols.
// Optional build macro SAM_TX_PARITY_EN appends an even-parity symbol after the data symbols.
module sam_pwm_tx #(
   parameter int unsigned DATA_W  = 8,
   parameter int unsigned T_LONG  = 20,
   parameter int unsigned T_SHORT = 10
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic [3:0]        cfg_n,
   input  logic [DATA_W-1:0] cfg_d,
   input  logic [DATA_W-1:0] cfg_caps,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [DATA_W-1:0] s_data,
   output logic              str,
   output logic              mode,
   output logic              busy,
   output logic              done
);

   localparam int unsigned CFG_W = 4 + 2 * DATA_W;
   localparam int unsigned CC_W  = $clog2(CFG_W);
   localparam int unsigned PH_W  = $clog2(T_LONG + 1);
`ifdef SAM_TX_PARITY_EN
   localparam int unsigned SYM_N = DATA_W + 1;
`else
   localparam int unsigned SYM_N = DATA_W;
`endif
   localparam int unsigned BI_W  = (SYM_N > 1) ? $clog2(SYM_N) : 1;

   typedef enum logic [2:0] {IDLE, CFG, SYM_HI, SYM_LO, STOP} state_t;

   state_t             state;
   logic [CFG_W-1:0]   cfg_sr;
   logic [CC_W-1:0]    cfg_cnt;
   logic [SYM_N-1:0]   sym_sr;
   logic [BI_W-1:0]    bit_idx;
   logic [PH_W-1:0]    ph_cnt;
   logic               rdy;

   // A '1' symbol is long-high/short-low, a '0' symbol short-high/long-low.
   function automatic logic [PH_W-1:0] hi_len(input logic b);
      return b ? PH_W'(T_LONG - 1) : PH_W'(T_SHORT - 1);
   endfunction

   function automatic logic [PH_W-1:0] lo_len(input logic b);
      return b ? PH_W'(T_SHORT - 1) : PH_W'(T_LONG - 1);
   endfunction

   // A pending config request always wins over a data word.
   assign s_ready = rdy & ~cfg_start;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         cfg_sr  <= '0;
         cfg_cnt <= '0;
         sym_sr  <= '0;
         bit_idx <= '0;
         ph_cnt  <= '0;
         rdy     <= 1'b0;
         str     <= 1'b0;
         mode    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               str  <= 1'b0;
               mode <= 1'b0;
               busy <= 1'b0;
               rdy  <= 1'b1;
               if (cfg_start) begin
                  state   <= CFG;
                  mode    <= 1'b1;
                  busy    <= 1'b1;
                  rdy     <= 1'b0;
                  str     <= cfg_n[3];
                  cfg_sr  <= {cfg_n[2:0], cfg_d, cfg_caps, 1'b0};
                  cfg_cnt <= CC_W'(CFG_W - 1);
               end else if (s_valid && rdy) begin
                  state   <= SYM_HI;
                  busy    <= 1'b1;
                  rdy     <= 1'b0;
                  str     <= 1'b1;
`ifdef SAM_TX_PARITY_EN
                  sym_sr  <= {s_data, ^s_data};
`else
                  sym_sr  <= s_data;
`endif
                  bit_idx <= BI_W'(SYM_N - 1);
                  ph_cnt  <= hi_len(s_data[DATA_W-1]);
               end
            end

            CFG: begin
               if (cfg_cnt == '0) begin
                  state <= IDLE;
                  mode  <= 1'b0;
                  str   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  rdy   <= 1'b1;
               end else begin
                  cfg_cnt <= cfg_cnt - CC_W'(1);
                  str     <= cfg_sr[CFG_W-1];
                  cfg_sr  <= cfg_sr << 1;
               end
            end

            SYM_HI: begin
               if (ph_cnt == '0) begin
                  state  <= SYM_LO;
                  str    <= 1'b0;
                  ph_cnt <= lo_len(sym_sr[SYM_N-1]);
               end else begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end
            end

            SYM_LO: begin
               if (ph_cnt != '0) begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end else if (bit_idx != '0) begin
                  state   <= SYM_HI;
                  str     <= 1'b1;
                  bit_idx <= bit_idx - BI_W'(1);
                  sym_sr  <= sym_sr << 1;
                  ph_cnt  <= hi_len(sym_sr[SYM_N-2]);
               end else begin
                  state  <= STOP;
                  str    <= 1'b1;
                  ph_cnt <= PH_W'(T_SHORT - 1);
               end
            end

            STOP: begin
               if (ph_cnt == '0) begin
                  state <= IDLE;
                  str   <= 1'b0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  rdy   <= 1'b1;
               end else begin
                  ph_cnt <= ph_cnt - PH_W'(1);
               end
            end

            default: begin
               state <= IDLE;
               str   <= 1'b0;
               mode  <= 1'b0;
               busy  <= 1'b0;
               rdy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sam_pwm_tx.sv
// Directed bench for sam_pwm_tx: reset, config frame, PWM data frames, back-to-back and mid-frame reset.
module tb_sam_pwm_tx;

   localparam int unsigned DATA_W  = 8;
   localparam int unsigned T_LONG  = 20;
   localparam int unsigned T_SHORT = 10;

   logic              clk;
   logic              reset;
   logic              cfg_start;
   logic [3:0]        cfg_n;
   logic [DATA_W-1:0] cfg_d;
   logic [DATA_W-1:0] cfg_caps;
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;
   logic              str;
   logic              mode;
   logic              busy;
   logic              done;

   int passed = 0;
   int total  = 0;

   sam_pwm_tx #(.DATA_W(DATA_W), .T_LONG(T_LONG), .T_SHORT(T_SHORT)) dut (
      .clk(clk), .reset(reset),
      .cfg_start(cfg_start), .cfg_n(cfg_n), .cfg_d(cfg_d), .cfg_caps(cfg_caps),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .str(str), .mode(mode), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   // Entered on the first cycle after the handshake; follows the frame up to and including done.
   task automatic run_frame(input logic [7:0] d, input string tag);
      bit   w[400];
      int   len, n, bad, nsym, hi, lo;
      logic b;
      len  = 0;
      nsym = 8;
`ifdef SAM_TX_PARITY_EN
      nsym = 9;
`endif
      for (int i = 0; i < nsym; i++) begin
         b  = (i < 8) ? d[7-i] : ^d;
         hi = b ? T_LONG : T_SHORT;
         lo = b ? T_SHORT : T_LONG;
         for (int j = 0; j < hi; j++) begin w[len] = 1'b1; len++; end
         for (int j = 0; j < lo; j++) begin w[len] = 1'b0; len++; end
      end
      for (int j = 0; j < T_SHORT; j++) begin w[len] = 1'b1; len++; end
      chk({tag, "_first_str"}, 32'(str), 32'd1);
      n   = 0;
      bad = 0;
      while (done !== 1'b1 && n < 390) begin
         if (n >= len || str !== w[n]) bad++;
         n++;
         tick();
      end
      chk({tag, "_done_latency"}, 32'(n + 1), 32'(len + 1));
      chk({tag, "_wave_bad_cycles"}, 32'(bad), 32'd0);
      chk({tag, "_str_at_done"}, 32'(str), 32'd0);
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
   endtask

   initial begin
      logic [19:0] cap;
      int          mode_bad;
      int          dn;

      reset = 1'b0; cfg_start = 1'b0; cfg_n = '0; cfg_d = '0; cfg_caps = '0;
      s_valid = 1'b0; s_data = '0;
      tick(); tick();
      chk("rst_str", 32'(str), 32'd0);
      chk("rst_mode", 32'(mode), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_ready", 32'(s_ready), 32'd0);

      reset = 1'b1;
      tick();
      chk("idle_ready", 32'(s_ready), 32'd1);
      chk("idle_str", 32'(str), 32'd0);
      chk("idle_busy", 32'(busy), 32'd0);

      // Config and data requested together: config goes first.
      cfg_start = 1'b1; cfg_n = 4'hA; cfg_d = 8'h3C; cfg_caps = 8'h81;
      s_valid = 1'b1; s_data = 8'hA5;
      #1;
      chk("prio_ready", 32'(s_ready), 32'd0);
      tick();
      cfg_start = 1'b0; cfg_n = 4'h0; cfg_d = 8'hFF; cfg_caps = 8'h00;
      chk("cfg_busy", 32'(busy), 32'd1);
      cap = '0;
      mode_bad = 0;
      for (int k = 0; k < 20; k++) begin
         cap = {cap[18:0], str};
         if (mode !== 1'b1) mode_bad++;
         tick();
      end
      chk("cfg_bits", 32'(cap), 32'hA3C81);
      chk("cfg_mode_bad", 32'(mode_bad), 32'd0);
      chk("cfg_end_mode", 32'(mode), 32'd0);
      chk("cfg_end_str", 32'(str), 32'd0);
      chk("cfg_done", 32'(done), 32'd1);
      chk("cfg_end_ready", 32'(s_ready), 32'd1);

      // Pending word accepted on this first idle cycle; later s_data changes are ignored.
      tick();
      s_valid = 1'b0; s_data = 8'h5A;
      chk("a5_busy", 32'(busy), 32'd1);
      chk("a5_mode", 32'(mode), 32'd0);
      chk("a5_done_low", 32'(done), 32'd0);
      run_frame(8'hA5, "a5");

      // Back-to-back FF then 00 with s_valid held high throughout.
      s_valid = 1'b1; s_data = 8'hFF;
      #1;
      chk("ff_ready", 32'(s_ready), 32'd1);
      tick();
      s_data = 8'h00;
      chk("ff_ready_busy", 32'(s_ready), 32'd0);
      run_frame(8'hFF, "ff");
      chk("b2b_ready", 32'(s_ready), 32'd1);
      tick();
      s_valid = 1'b0;
      run_frame(8'h00, "z0");

      tick();
      s_valid = 1'b1; s_data = 8'h07;
      tick();
      s_valid = 1'b0;
      run_frame(8'h07, "p07");

      // Reset at cycle 100 of a data frame aborts it with no done.
      tick();
      s_valid = 1'b1; s_data = 8'hA5;
      tick();
      s_valid = 1'b0;
      for (int k = 1; k < 100; k++) tick();
      chk("mid_busy_before", 32'(busy), 32'd1);
      reset = 1'b0;
      #1;
      chk("abort_str", 32'(str), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_ready", 32'(s_ready), 32'd0);
      dn = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done !== 1'b0) dn++;
      end
      reset = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         if (done !== 1'b0 || str !== 1'b0) dn++;
      end
      chk("abort_no_done", 32'(dn), 32'd0);
      chk("abort_idle_ready", 32'(s_ready), 32'd1);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/sam_pwm_tx.md
Name: sam_pwm_tx

Overview:
Upstream transmit stage for the SAM serial decoder. It drives the decoder's `str` and `mode` lines.
- Config phase: with `mode`=1, shifts a 4-bit n-field, a DATA_W key (d) and a DATA_W caps mask one bit per clock, MSB first.
- Data phase: with `mode`=0, sends each accepted message word as pulse-width-modulated symbols, then a stop mark.

Parameters:
DATA_W, 8, message/key/mask width in bits
T_LONG, 20, long-phase length in clocks (must be > T_SHORT)
T_SHORT, 10, short-phase length in clocks (>=1; T_LONG+T_SHORT must lie in 10..60)

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-low reset
cfg_start  input  1  single-cycle request to send a config frame (sampled in IDLE only)
cfg_n  input  4  n-field, captured on cfg_start
cfg_d  input  DATA_W  key, captured on cfg_start
cfg_caps  input  DATA_W  caps mask, captured on cfg_start
s_valid  input  1  message word valid
s_ready  output  1  high only in IDLE with cfg_start low
s_data  input  DATA_W  message word, captured on s_valid&&s_ready
str  output  1  serial line to decoder
mode  output  1  1 = config bits on str, 0 = PWM data
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse when a config or data frame completes

Behaviour:
- Reset (async, active-low): state=IDLE; str=0, mode=0, busy=0, done=0, s_ready=0 while reset is asserted. All counters and shift registers are cleared. Reset mid-frame aborts immediately; no partial stop mark is sent.
- FSM states: IDLE, CFG, SYM_HI, SYM_LO, STOP. All outputs are registered.
- IDLE:
  - str=0, mode=0.
  - cfg_start has priority over s_valid in the same cycle; the data word is not accepted (s_ready=0 that cycle).
  - cfg_start -> CFG: loads the 4+2*DATA_W-bit shift register {cfg_n, cfg_d, cfg_caps}.
  - s_valid&&s_ready -> SYM_HI: loads s_data, bit_idx=DATA_W-1.
- CFG:
  - mode=1 for exactly 4+2*DATA_W cycles (20 at defaults). Cycle k drives str = shift-register bit MSB-k.
  - The first config bit appears the cycle after cfg_start.
  - Then mode=0, str=0, done pulses for 1 cycle, return to IDLE.
- SYM_HI: str=1 for T_LONG cycles if the current bit is 1, else T_SHORT cycles; then -> SYM_LO.
- SYM_LO:
  - str=0 for T_SHORT cycles if the bit is 1, else T_LONG cycles.
  - Then: bit_idx>0 -> decrement bit_idx, SYM_HI; bit_idx==0 -> STOP.
  - Each symbol is exactly T_LONG+T_SHORT cycles. Bits go MSB first.
- STOP:
  - str=1 for T_SHORT cycles. Its rising edge terminates the last symbol for the decoder.
  - Then str=0, done pulses, return to IDLE.
- Latency: str rises the cycle after the handshake.
  - Data frame = DATA_W*(T_LONG+T_SHORT)+T_SHORT cycles: 250 at defaults.
  - done is asserted the cycle after the last STOP high cycle.
- Phase counter: width clog2(T_LONG+1); counts down from phase length-1 and reloads on every phase transition. It never wraps.
- Back-to-back frames: after done, IDLE lasts at least 1 cycle with str=0, so the next frame's first rising edge is clean.
- s_data and cfg_* changing while busy has no effect; inputs are captured only at the handshake.
- s_valid held high while busy: the word is not accepted until IDLE (s_ready=0).

Optional Feature:
SAM_TX_PARITY_EN
- Defined: after the DATA_W data symbols, one extra symbol carries even parity (XOR of all data bits), encoded identically, before STOP. Frame = (DATA_W+1)*(T_LONG+T_SHORT)+T_SHORT cycles (280 at defaults).
- Undefined: no parity symbol. Logic and state for parity are absent.

Test Plan:
- Reset held, then released -> str=0, mode=0, busy=0, s_ready=1 on the first clock in IDLE. Assert reset at cycle 100 of a data frame -> str=0, busy=0 immediately; no done.
- cfg_start with cfg_n=4'hA, cfg_d=8'h3C, cfg_caps=8'h81 -> mode=1 for 20 cycles. str sequence = 1010_00111100_10000001. Then mode=0, done pulse.
- s_data=8'hA5 -> symbols 1,0,1,0,0,1,0,1; each '1' = 20 high/10 low, each '0' = 10 high/20 low. Then 10-cycle stop high; done at cycle 251 after the handshake.
- cfg_start and s_valid asserted together in IDLE -> config frame sent first, s_ready=0 that cycle. Data word accepted in the first IDLE cycle after config done.
- Back-to-back s_valid with 8'hFF then 8'h00 -> second frame starts 2 cycles after the first frame's last stop-high cycle. All-long-high then all-long-low symbols, each exactly 30 cycles.
- SAM_TX_PARITY_EN defined, s_data=8'h07 -> 9th symbol is '1' (20/10); frame length 280 cycles before done.
